gf180mcu_fd_sc_mcu9t5v0__rrarb4_1: RTL and testbench



---
 rtl/gf180mcu_fd_sc_mcu9t5v0__rrarb4_pkg.sv | 17 +
 rtl/gf180mcu_fd_sc_mcu9t5v0__rrarb4_pick.sv | 26 ++
 rtl/gf180mcu_fd_sc_mcu9t5v0__rrarb4_1.sv | 129 ++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__rrarb4_1.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rrarb4_pkg.sv
// Shared types and constants for the four-way round-robin grant cell.
package gf180mcu_fd_sc_mcu9t5v0__rrarb4_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [1:0] IDX_A1 = 2'd0;
  localparam logic [1:0] IDX_A2 = 2'd1;
  localparam logic [1:0] IDX_A3 = 2'd2;
  localparam logic [1:0] IDX_A4 = 2'd3;

  // Last-served pointer after reset, so that A1 is examined first.
  localparam logic [1:0] PTR_RST = 2'd3;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rrarb4_pick.sv
// Rotate-and-priority picker: first asserted request after the last-served index.
module gf180mcu_fd_sc_mcu9t5v0__rrarb4_pick
  import gf180mcu_fd_sc_mcu9t5v0__rrarb4_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] winner
);

  logic [1:0] cand;

  always_comb begin
    valid  = 1'b0;
    winner = ptr;
    cand   = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = ptr + 2'(i);
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rrarb4_1.sv
// Four-way round-robin grant cell with registered one-hot grants and bounded tenure.
module gf180mcu_fd_sc_mcu9t5v0__rrarb4_1
  import gf180mcu_fd_sc_mcu9t5v0__rrarb4_pkg::*;
#(
  parameter int unsigned MAXHOLD = 8
)
(
`ifdef USE_POWER_PINS
  inout  wire  VDD,
  inout  wire  VSS,
`endif
  input  logic CLK,
  input  logic RN,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic A4,
  output logic G1,
  output logic G2,
  output logic G3,
  output logic G4,
  output logic Z
);

  localparam int unsigned CW = (MAXHOLD == 0) ? 1 : $clog2(MAXHOLD + 1);
  localparam logic [CW-1:0] HOLD = CW'(MAXHOLD);

  state_t          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      g_q, g_d;
  logic            z_q, z_d;

  logic [3:0]      req;
  logic            pick_valid;
  logic [1:0]      pick_win;
  logic            expire;

  assign req[IDX_A1] = A1;
  assign req[IDX_A2] = A2;
  assign req[IDX_A3] = A3;
  assign req[IDX_A4] = A4;

  gf180mcu_fd_sc_mcu9t5v0__rrarb4_pick u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .winner (pick_win)
  );

  assign expire = (MAXHOLD != 0) && (cnt_q == HOLD);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    g_d     = g_q;
    z_d     = z_q;
    case (state_q)
      IDLE: begin
        g_d = '0;
        z_d = 1'b0;
        if (pick_valid) begin
          state_d = GRANT;
          idx_d   = pick_win;
          cnt_d   = CW'(1);
          g_d     = 4'b0001 << pick_win;
          z_d     = 1'b1;
        end
      end
      GRANT: begin
        // Release and expiry share one exit path, so a coincident pair behaves as a release.
        if (!req[idx_q] || expire) begin
          state_d = IDLE;
          ptr_d   = idx_q;
          g_d     = '0;
          z_d     = 1'b0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        g_d     = '0;
        z_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      ptr_q   <= PTR_RST;
      idx_q   <= '0;
      cnt_q   <= '0;
      g_q     <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      g_q     <= g_d;
      z_q     <= z_d;
    end
  end

  assign G1 = g_q[IDX_A1];
  assign G2 = g_q[IDX_A2];
  assign G3 = g_q[IDX_A3];
  assign G4 = g_q[IDX_A4];
  assign Z  = z_q;

  specify
    (CLK => G1) = (0, 0);
    (CLK => G2) = (0, 0);
    (CLK => G3) = (0, 0);
    (CLK => G4) = (0, 0);
    (CLK => Z)  = (0, 0);
    (RN  => G1) = (0, 0);
    (RN  => G2) = (0, 0);
    (RN  => G3) = (0, 0);
    (RN  => G4) = (0, 0);
    (RN  => Z)  = (0, 0);
  endspecify

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__rrarb4_1.sv
// Bench for the round-robin grant cell: three tenure limits driven in parallel against a reference model.
module tb_gf180mcu_fd_sc_mcu9t5v0__rrarb4_1;

  logic       clk = 1'b0;
  logic       rn  = 1'b0;
  logic [3:0] a   = 4'b0000;

  logic [3:0] g_h2, g_h8, g_h0;
  logic       z_h2, z_h8, z_h0;
  logic [3:0] obs_g [3];
  logic       obs_z [3];

  int hold_of [3] = '{2, 8, 0};
  int own  [3];
  int last [3];
  int ten  [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu9t5v0__rrarb4_1 #(.MAXHOLD(2)) u_h2 (
    .CLK(clk), .RN(rn), .A1(a[0]), .A2(a[1]), .A3(a[2]), .A4(a[3]),
    .G1(g_h2[0]), .G2(g_h2[1]), .G3(g_h2[2]), .G4(g_h2[3]), .Z(z_h2)
  );
  gf180mcu_fd_sc_mcu9t5v0__rrarb4_1 #(.MAXHOLD(8)) u_h8 (
    .CLK(clk), .RN(rn), .A1(a[0]), .A2(a[1]), .A3(a[2]), .A4(a[3]),
    .G1(g_h8[0]), .G2(g_h8[1]), .G3(g_h8[2]), .G4(g_h8[3]), .Z(z_h8)
  );
  gf180mcu_fd_sc_mcu9t5v0__rrarb4_1 #(.MAXHOLD(0)) u_h0 (
    .CLK(clk), .RN(rn), .A1(a[0]), .A2(a[1]), .A3(a[2]), .A4(a[3]),
    .G1(g_h0[0]), .G2(g_h0[1]), .G3(g_h0[2]), .G4(g_h0[3]), .Z(z_h0)
  );

  assign obs_g[0] = g_h2;
  assign obs_g[1] = g_h8;
  assign obs_g[2] = g_h0;
  assign obs_z[0] = z_h2;
  assign obs_z[1] = z_h8;
  assign obs_z[2] = z_h0;

  // Reference: owner index (-1 = nobody), tenure length, last-served requester.
  always @(posedge clk or negedge rn) begin
    for (int k = 0; k < 3; k++) begin
      if (!rn) begin
        own[k] = -1; last[k] = 3; ten[k] = 0;
      end else if (own[k] < 0) begin
        for (int off = 1; off <= 4 && own[k] < 0; off++)
          if (a[(last[k] + off) % 4]) begin
            own[k] = (last[k] + off) % 4;
            ten[k] = 1;
          end
      end else if (!a[own[k]] || (hold_of[k] != 0 && ten[k] == hold_of[k])) begin
        last[k] = own[k];
        own[k]  = -1;
      end else begin
        ten[k]++;
      end
    end
  end

  task automatic apply_reset(input logic [3:0] req);
    @(negedge clk);
    rn = 1'b0;
    a  = req;
    @(negedge clk);
    @(negedge clk);
    rn = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] e;
    @(negedge clk);
    rn = 1'b0;
    a  = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs_g[k] !== 4'b0000 || obs_z[k] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_hold inst=%0d: G=%b Z=%b, expected G=0000 Z=0", k, obs_g[k], obs_z[k]);
        end
      end
    end
    rn = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      e = (own[k] < 0) ? 4'b0000 : (4'b0001 << own[k]);
      n_checks++;
      if (obs_g[k] !== 4'b0001 || obs_z[k] !== 1'b1 || e !== 4'b0001) begin
        n_fail++;
        $display("FAIL reset_release inst=%0d: G=%b Z=%b model=%b, expected G=0001 Z=1", k, obs_g[k], obs_z[k], e);
      end
    end
  endtask

  task automatic test_expiry();
    logic [3:0] e;
    logic [3:0] want;
    apply_reset(4'b1111);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      want = (i % 3 == 2) ? 4'b0000 : (4'b0001 << ((i / 3) % 4));
      n_checks++;
      if (g_h2 !== want || z_h2 !== (want != 4'b0000)) begin
        n_fail++;
        $display("FAIL expiry_pattern cycle=%0d: G=%b Z=%b, expected G=%b Z=%b", i, g_h2, z_h2, want, want != 4'b0000);
      end
      for (int k = 0; k < 3; k++) begin
        e = (own[k] < 0) ? 4'b0000 : (4'b0001 << own[k]);
        n_checks++;
        if (obs_g[k] !== e || obs_z[k] !== (e != 4'b0000)) begin
          n_fail++;
          $display("FAIL expiry_model cycle=%0d inst=%0d: G=%b Z=%b, expected G=%b", i, k, obs_g[k], obs_z[k], e);
        end
      end
    end
  endtask

  task automatic test_pulse();
    logic [3:0] e;
    logic [3:0] want;
    apply_reset(4'b0000);
    @(negedge clk);
    a = 4'b0100;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      want = (i <= 3) ? 4'b0100 : 4'b0000;
      n_checks++;
      if (g_h8 !== want || z_h8 !== (want != 4'b0000)) begin
        n_fail++;
        $display("FAIL pulse cycle=%0d: G=%b Z=%b, expected G=%b", i, g_h8, z_h8, want);
      end
      for (int k = 0; k < 3; k++) begin
        e = (own[k] < 0) ? 4'b0000 : (4'b0001 << own[k]);
        n_checks++;
        if (obs_g[k] !== e || obs_z[k] !== (e != 4'b0000)) begin
          n_fail++;
          $display("FAIL pulse_model cycle=%0d inst=%0d: G=%b Z=%b, expected G=%b", i, k, obs_g[k], obs_z[k], e);
        end
      end
      if (i == 3) a = 4'b0000;
    end
  endtask

  task automatic test_rotation();
    logic [3:0] want [6] = '{4'b0010, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b0001};
    logic [3:0] stim [6] = '{4'b0010, 4'b0000, 4'b0101, 4'b0001, 4'b0001, 4'b0000};
    apply_reset(4'b0000);
    @(negedge clk);
    a = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs_g[k] !== want[i] || obs_z[k] !== (want[i] != 4'b0000)) begin
          n_fail++;
          $display("FAIL rotation step=%0d inst=%0d: G=%b Z=%b, expected G=%b", i, k, obs_g[k], obs_z[k], want[i]);
        end
      end
      a = stim[i];
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] e;
    apply_reset(4'b0000);
    @(negedge clk);
    a = 4'b1000;
    @(negedge clk);
    n_checks++;
    if (g_h8 !== 4'b1000 || z_h8 !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre inst=1: G=%b Z=%b, expected G=1000 Z=1", g_h8, z_h8);
    end
    #2 rn = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (obs_g[k] !== 4'b0000 || obs_z[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL async_drop inst=%0d: G=%b Z=%b, expected G=0000 Z=0", k, obs_g[k], obs_z[k]);
      end
    end
    @(negedge clk);
    a  = 4'b1001;
    rn = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      e = (own[k] < 0) ? 4'b0000 : (4'b0001 << own[k]);
      n_checks++;
      if (obs_g[k] !== 4'b0001 || obs_z[k] !== 1'b1 || e !== 4'b0001) begin
        n_fail++;
        $display("FAIL async_rearb inst=%0d: G=%b Z=%b model=%b, expected G=0001", k, obs_g[k], obs_z[k], e);
      end
    end
  endtask

  task automatic test_unlimited();
    logic [3:0] e;
    int bad = 0;
    apply_reset(4'b0000);
    @(negedge clk);
    a = 4'b0110;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (g_h0 !== 4'b0010 || z_h0 !== 1'b1) bad++;
      for (int k = 0; k < 3; k++) begin
        e = (own[k] < 0) ? 4'b0000 : (4'b0001 << own[k]);
        n_checks++;
        if (obs_g[k] !== e || obs_z[k] !== (e != 4'b0000)) begin
          n_fail++;
          $display("FAIL unlimited_model cycle=%0d inst=%0d: G=%b Z=%b, expected G=%b", i, k, obs_g[k], obs_z[k], e);
        end
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL unlimited_hold: %0d of 300 cycles without G2, expected 0", bad);
    end
    a = 4'b0100;
    @(negedge clk);
    n_checks++;
    if (g_h0 !== 4'b0000 || z_h0 !== 1'b0) begin
      n_fail++;
      $display("FAIL unlimited_gap: G=%b Z=%b, expected G=0000 Z=0", g_h0, z_h0);
    end
    @(negedge clk);
    n_checks++;
    if (g_h0 !== 4'b0100 || z_h0 !== 1'b1) begin
      n_fail++;
      $display("FAIL unlimited_next: G=%b Z=%b, expected G=0100 Z=1", g_h0, z_h0);
    end
  endtask

  task automatic test_random();
    logic [3:0] e;
    apply_reset(4'b0000);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        e = (own[k] < 0) ? 4'b0000 : (4'b0001 << own[k]);
        n_checks++;
        if (obs_g[k] !== e || obs_z[k] !== (e != 4'b0000)) begin
          n_fail++;
          $display("FAIL random cycle=%0d inst=%0d: G=%b Z=%b, expected G=%b", c, k, obs_g[k], obs_z[k], e);
        end
      end
      if ($urandom_range(0, 49) == 0) begin
        rn = 1'b0;
      end else begin
        rn = 1'b1;
        if ($urandom_range(0, 2) == 0) a = 4'($urandom);
      end
    end
    rn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_expiry();
    test_pulse();
    test_rotation();
    test_async_reset();
    test_unlimited();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
